// File: rtl/secd_iter_array_mult.sv
// Iterative shift-add multiplier retiring STEP partial-product rows per clock, signed/unsigned per transaction.
// Optional accumulate mode (acc_en port) enabled by defining SECD_MULT_ACC_EN.
module secd_iter_array_mult #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               signed_mode,
`ifdef SECD_MULT_ACC_EN
    input  logic               acc_en,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned ITER  = WIDTH / STEP;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    generate
        if ((STEP == 0) || (WIDTH % STEP != 0)) begin : g_bad_step
            $error("secd_iter_array_mult: STEP must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [PW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;
    logic [PW-1:0]      acc;
    logic               neg;
    logic               acc_mode;
    logic               accept_c;
    logic               last_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;
    logic [PW-1:0]      acc_sum_c;
    logic [PW-1:0]      result_c;
    logic [PW-1:0]      final_c;
    logic               acc_req_c;

`ifdef SECD_MULT_ACC_EN
    assign acc_req_c = acc_en;
`else
    assign acc_req_c = 1'b0;
`endif

    // State register; ena freezes the FSM along with everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(ITER - 1)) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    always_comb begin
        a_mag_c = (signed_mode && op_a[WIDTH-1]) ? WIDTH'(-op_a) : op_a;
        b_mag_c = (signed_mode && op_b[WIDTH-1]) ? WIDTH'(-op_b) : op_b;
    end

    // STEP shifted partial products selected by the low multiplier bits
    always_comb begin
        acc_sum_c = acc;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (mplier[i]) begin
                acc_sum_c = acc_sum_c + (mcand << i);
            end
        end
        result_c = neg ? PW'(-acc_sum_c) : acc_sum_c;
        final_c  = acc_mode ? PW'(product + result_c) : result_c;
    end

    // Datapath and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            acc_mode  <= 1'b0;
            product   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (ena) begin
            if (accept_c) begin
                mcand    <= PW'(a_mag_c);
                mplier   <= b_mag_c;
                neg      <= signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                acc_mode <= acc_req_c;
                acc      <= '0;
                cnt      <= '0;
            end else if (state == BUSY) begin
                acc    <= acc_sum_c;
                mcand  <= mcand << STEP;
                mplier <= mplier >> STEP;
                cnt    <= last_c ? '0 : cnt + CNT_W'(1);
                if (last_c) begin
                    product <= final_c;
                end
            end
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

endmodule
